cmp_chk: RTL and testbench

Multi-channel, parametrised compare checker; the next generation of the per-instance signal comparator used in the DUV bench.
- Compares up to CHANNELS expected/actual pairs per cycle under a per-channel valid and enable mask.
- Keeps saturating per-channel and total error counters and captures the first mismatch.
- Raises a sticky finish request once a configurable error threshold is reached, for the simulation controller to act on.

---
 rtl/cmp_chk.sv | 225 ++++++++++++++++++++++
 tb/tb_cmp_chk.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_chk.sv
// ----------------------------------------------------------------------------
// cmp_chk -- multi-channel compare checker
//
// Compares up to CHANNELS expected/actual pairs per cycle under a per-channel
// valid and enable mask. It keeps saturating per-channel and total error
// counters and captures the first mismatch. A sticky finish request is raised
// once the total error count reaches THRESHOLD.
//
// Parameters:
//   CHANNELS  number of compare channels (1..64)
//   WIDTH     bits per compared value (1..256)
//   CNT_W     width of every counter
//   THRESHOLD total errors that trigger FAILED; 0 disables failing
//   CH_W      derived channel-index width, not user-set
//
// Ports:
//   chk_clk_ip        clock, all state on the rising edge
//   chk_rst_n_ip      asynchronous active-low reset
//   chk_en_ip         checker enable
//   chk_clr_ip        synchronous clear (counters, first record, state)
//   chk_mask_ip       per-channel participate mask
//   chk_vld_ip        per-channel sample valid
//   chk_exp_ip        expected values, channel i at [i*WIDTH +: WIDTH]
//   chk_act_ip        actual values, same packing
//   chk_err_cnt_op    per-channel mismatch counts, channel i at [i*CNT_W +: CNT_W]
//   chk_cmp_cnt_op    total compares performed
//   chk_tot_err_op    total mismatches
//   chk_first_vld_op  first-mismatch record valid
//   chk_first_ch_op   channel of the first mismatch
//   chk_first_exp_op  expected value at the first mismatch
//   chk_first_act_op  actual value at the first mismatch
//   chk_state_op      IDLE=0, ARMED=1, FAILED=2
//   chk_finish_op     finish request, high while in FAILED
//
// Build option:
//   CMP_CHK_MSG_EN    when defined (simulation only), prints one error
//                     message per mismatch and one info message on entry to
//                     FAILED. Cycle behaviour is identical either way.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | checker disabled, no compares, counters hold
// ARMED  | compares active while enabled, counting errors
// FAILED | threshold reached; keeps counting, sticky until clear or reset
// ----------------------------------------------------------------------------
module cmp_chk #(
    parameter  int CHANNELS  = 4,
    parameter  int WIDTH     = 32,
    parameter  int CNT_W     = 16,
    parameter  int THRESHOLD = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      chk_clk_ip,
    input  logic                      chk_rst_n_ip,
    input  logic                      chk_en_ip,
    input  logic                      chk_clr_ip,
    input  logic [CHANNELS-1:0]       chk_mask_ip,
    input  logic [CHANNELS-1:0]       chk_vld_ip,
    input  logic [CHANNELS*WIDTH-1:0] chk_exp_ip,
    input  logic [CHANNELS*WIDTH-1:0] chk_act_ip,
    output logic [CHANNELS*CNT_W-1:0] chk_err_cnt_op,
    output logic [CNT_W-1:0]          chk_cmp_cnt_op,
    output logic [CNT_W-1:0]          chk_tot_err_op,
    output logic                      chk_first_vld_op,
    output logic [CH_W-1:0]           chk_first_ch_op,
    output logic [WIDTH-1:0]          chk_first_exp_op,
    output logic [WIDTH-1:0]          chk_first_act_op,
    output logic [1:0]                chk_state_op,
    output logic                      chk_finish_op
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    // Seven guard bits hold up to 64 channels added onto a full counter, so
    // the threshold compare sees the true sum before saturation.
    localparam int               SUM_W   = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] THR     = SUM_W'(THRESHOLD);
    localparam bit               THR_EN  = (THRESHOLD != 0);

    state_t                 state_q, state_d;
    logic [CHANNELS-1:0]    active, mism;
    logic [SUM_W-1:0]       n_cmp, n_err, cmp_sum, tot_sum;
    logic [CNT_W-1:0]       cmp_cnt_q, cmp_cnt_d;
    logic [CNT_W-1:0]       tot_err_q, tot_err_d;
    logic [CNT_W-1:0]       err_cnt_q [CHANNELS];
    logic [CNT_W-1:0]       err_cnt_d [CHANNELS];
    logic                   first_vld_q, first_vld_d;
    logic [CH_W-1:0]        first_ch_q, first_ch_d;
    logic [WIDTH-1:0]       first_exp_q, first_exp_d;
    logic [WIDTH-1:0]       first_act_q, first_act_d;
    logic                   finish_q;

    function automatic logic [CNT_W-1:0] sat(input logic [SUM_W-1:0] v);
        return (v > SUM_W'(CNT_MAX)) ? CNT_MAX : v[CNT_W-1:0];
    endfunction

    always_comb begin
        active = '0;
        mism   = '0;
        n_cmp  = '0;
        n_err  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            active[i] = (state_q != ST_IDLE) && chk_en_ip && chk_mask_ip[i] && chk_vld_ip[i];
            mism[i]   = active[i] &&
                        (chk_exp_ip[i*WIDTH +: WIDTH] != chk_act_ip[i*WIDTH +: WIDTH]);
            n_cmp     = n_cmp + SUM_W'(active[i]);
            n_err     = n_err + SUM_W'(mism[i]);
        end
        cmp_sum = SUM_W'(cmp_cnt_q) + n_cmp;
        tot_sum = SUM_W'(tot_err_q) + n_err;
    end

    always_comb begin
        state_d     = state_q;
        cmp_cnt_d   = sat(cmp_sum);
        tot_err_d   = sat(tot_sum);
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;
        first_exp_d = first_exp_q;
        first_act_d = first_act_q;
        for (int i = 0; i < CHANNELS; i++) begin
            err_cnt_d[i] = (mism[i] && (err_cnt_q[i] != CNT_MAX))
                         ? err_cnt_q[i] + CNT_W'(1) : err_cnt_q[i];
        end

        // Descending scan so the lowest-index mismatching channel is kept.
        if (!first_vld_q) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                if (mism[i]) begin
                    first_vld_d = 1'b1;
                    first_ch_d  = CH_W'(i);
                    first_exp_d = chk_exp_ip[i*WIDTH +: WIDTH];
                    first_act_d = chk_act_ip[i*WIDTH +: WIDTH];
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (chk_en_ip) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (THR_EN && (tot_sum >= THR)) state_d = ST_FAILED;
                else if (!chk_en_ip)            state_d = ST_IDLE;
            end
            ST_FAILED: state_d = ST_FAILED;
            default:   state_d = ST_IDLE;
        endcase

        // Clear wins over everything, including this cycle's compares.
        if (chk_clr_ip) begin
            state_d     = ST_IDLE;
            cmp_cnt_d   = '0;
            tot_err_d   = '0;
            first_vld_d = 1'b0;
            first_ch_d  = '0;
            first_exp_d = '0;
            first_act_d = '0;
            for (int i = 0; i < CHANNELS; i++) err_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge chk_clk_ip or negedge chk_rst_n_ip) begin
        if (!chk_rst_n_ip) begin
            state_q     <= ST_IDLE;
            cmp_cnt_q   <= '0;
            tot_err_q   <= '0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
            first_exp_q <= '0;
            first_act_q <= '0;
            finish_q    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) err_cnt_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmp_cnt_q   <= cmp_cnt_d;
            tot_err_q   <= tot_err_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
            first_exp_q <= first_exp_d;
            first_act_q <= first_act_d;
            finish_q    <= (state_d == ST_FAILED);
            for (int i = 0; i < CHANNELS; i++) err_cnt_q[i] <= err_cnt_d[i];
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_err_pack
        assign chk_err_cnt_op[g*CNT_W +: CNT_W] = err_cnt_q[g];
    end

    assign chk_cmp_cnt_op   = cmp_cnt_q;
    assign chk_tot_err_op   = tot_err_q;
    assign chk_first_vld_op = first_vld_q;
    assign chk_first_ch_op  = first_ch_q;
    assign chk_first_exp_op = first_exp_q;
    assign chk_first_act_op = first_act_q;
    assign chk_state_op     = state_q;
    assign chk_finish_op    = finish_q;

`ifdef CMP_CHK_MSG_EN
    // Messages follow the same edge that commits the update; discarded
    // (cleared) cycles stay silent.
    always @(posedge chk_clk_ip) begin
        if (chk_rst_n_ip && !chk_clr_ip) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (mism[i]) begin
                    $error("%m: channel %0d mismatch exp=%h act=%h", i,
                           chk_exp_ip[i*WIDTH +: WIDTH], chk_act_ip[i*WIDTH +: WIDTH]);
                end
            end
            if ((state_q != ST_FAILED) && (state_d == ST_FAILED)) begin
                $info("%m: entering FAILED, tot_err=%0d", tot_err_d);
            end
        end
    end
`else
    // Synthesis build: no messages.
`endif

endmodule

// File: tb/tb_cmp_chk.sv
module tb_cmp_chk;

    logic         clk = 1'b0;
    logic         rst_n, clr, en;
    logic [3:0]   mask, vld;
    logic [127:0] exp_v, act_v;

    // Main instance: 16-bit counters, fails at 3 errors.
    logic [63:0]  a_err;
    logic [15:0]  a_cmp, a_tot;
    logic         a_fvld, a_fin;
    logic [1:0]   a_fch, a_st;
    logic [31:0]  a_fexp, a_fact;

    // Saturation instance: 4-bit counters, never fails.
    logic [15:0]  s_err;
    logic [3:0]   s_cmp, s_tot;
    logic         s_fvld, s_fin;
    logic [1:0]   s_fch, s_st;
    logic [31:0]  s_fexp, s_fact;

    // Pre-saturation threshold instance: 2-bit counters, threshold 5.
    logic [7:0]   t_err;
    logic [1:0]   t_cmp, t_tot;
    logic         t_fvld, t_fin;
    logic [1:0]   t_fch, t_st;
    logic [31:0]  t_fexp, t_fact;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmp_chk #(.CHANNELS(4), .WIDTH(32), .CNT_W(16), .THRESHOLD(3)) dut_a (
        .chk_clk_ip(clk), .chk_rst_n_ip(rst_n), .chk_en_ip(en), .chk_clr_ip(clr),
        .chk_mask_ip(mask), .chk_vld_ip(vld), .chk_exp_ip(exp_v), .chk_act_ip(act_v),
        .chk_err_cnt_op(a_err), .chk_cmp_cnt_op(a_cmp), .chk_tot_err_op(a_tot),
        .chk_first_vld_op(a_fvld), .chk_first_ch_op(a_fch), .chk_first_exp_op(a_fexp),
        .chk_first_act_op(a_fact), .chk_state_op(a_st), .chk_finish_op(a_fin));

    cmp_chk #(.CHANNELS(4), .WIDTH(32), .CNT_W(4), .THRESHOLD(0)) dut_s (
        .chk_clk_ip(clk), .chk_rst_n_ip(rst_n), .chk_en_ip(en), .chk_clr_ip(clr),
        .chk_mask_ip(mask), .chk_vld_ip(vld), .chk_exp_ip(exp_v), .chk_act_ip(act_v),
        .chk_err_cnt_op(s_err), .chk_cmp_cnt_op(s_cmp), .chk_tot_err_op(s_tot),
        .chk_first_vld_op(s_fvld), .chk_first_ch_op(s_fch), .chk_first_exp_op(s_fexp),
        .chk_first_act_op(s_fact), .chk_state_op(s_st), .chk_finish_op(s_fin));

    cmp_chk #(.CHANNELS(4), .WIDTH(32), .CNT_W(2), .THRESHOLD(5)) dut_t (
        .chk_clk_ip(clk), .chk_rst_n_ip(rst_n), .chk_en_ip(en), .chk_clr_ip(clr),
        .chk_mask_ip(mask), .chk_vld_ip(vld), .chk_exp_ip(exp_v), .chk_act_ip(act_v),
        .chk_err_cnt_op(t_err), .chk_cmp_cnt_op(t_cmp), .chk_tot_err_op(t_tot),
        .chk_first_vld_op(t_fvld), .chk_first_ch_op(t_fch), .chk_first_exp_op(t_fexp),
        .chk_first_act_op(t_fact), .chk_state_op(t_st), .chk_finish_op(t_fin));

    typedef struct {
        logic        clr, en;
        logic [3:0]  mask, vld, mis;
        logic [31:0] xr;
        logic [1:0]  e_st;
        logic [15:0] e_cmp, e_tot;
        logic [63:0] e_err;
        logic        e_fvld;
        logic [1:0]  e_fch;
        logic [31:0] e_fexp, e_fact;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic c, e, input logic [3:0] m, v, mi,
                                input logic [31:0] x, input logic [1:0] st,
                                input logic [15:0] cm, tt, input logic [63:0] er,
                                input logic fv, input logic [1:0] fc,
                                input logic [31:0] fe, fa);
        vec_t r;
        r.clr = c; r.en = e; r.mask = m; r.vld = v; r.mis = mi; r.xr = x;
        r.e_st = st; r.e_cmp = cm; r.e_tot = tt; r.e_err = er;
        r.e_fvld = fv; r.e_fch = fc; r.e_fexp = fe; r.e_fact = fa;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    // Every channel expects 32'h55; mismatching channels see 32'h55 ^ x.
    task automatic drive(input logic c, e, input logic [3:0] m, v, mi, input logic [31:0] x);
        clr  = c;
        en   = e;
        mask = m;
        vld  = v;
        for (int i = 0; i < 4; i++) begin
            exp_v[i*32 +: 32] = 32'h55;
            act_v[i*32 +: 32] = mi[i] ? (32'h55 ^ x) : 32'h55;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] e_a, e_b, e_c, e_d;
        logic [15:0] w;

        e_a = {16'd1, 16'd0, 16'd1, 16'd0};
        e_b = {16'd1, 16'd0, 16'd1, 16'd1};
        e_c = {16'd1, 16'd1, 16'd1, 16'd1};
        e_d = e_c;

        // arm from IDLE, then clean run of 10 cycles
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'h0, 32'h0, 2'd1, 16'd0, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        for (int k = 1; k <= 10; k++)
            vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'h0, 32'h0, 2'd1, 16'(4*k), 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        // ch1 and ch3 mismatch together, ch1 captured
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'hA, 32'hFF, 2'd1, 16'd44, 16'd2, e_a, 1, 2'd1, 32'h55, 32'hAA));
        // no valid, then partial valid
        vq.push_back(mk(0, 1, 4'hF, 4'h0, 4'hF, 32'hFF, 2'd1, 16'd44, 16'd2, e_a, 1, 2'd1, 32'h55, 32'hAA));
        vq.push_back(mk(0, 1, 4'hF, 4'h3, 4'h0, 32'h0, 2'd1, 16'd46, 16'd2, e_a, 1, 2'd1, 32'h55, 32'hAA));
        // third error reaches the threshold
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'h1, 32'hFF, 2'd2, 16'd50, 16'd3, e_b, 1, 2'd1, 32'h55, 32'hAA));
        // FAILED ignores en=0, keeps counting when enabled, record untouched
        vq.push_back(mk(0, 0, 4'hF, 4'hF, 4'hF, 32'hFF, 2'd2, 16'd50, 16'd3, e_b, 1, 2'd1, 32'h55, 32'hAA));
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'h4, 32'hFF, 2'd2, 16'd54, 16'd4, e_c, 1, 2'd1, 32'h55, 32'hAA));
        // clear against a mismatch while FAILED
        vq.push_back(mk(1, 1, 4'hF, 4'hF, 4'h1, 32'hFF, 2'd0, 16'd0, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        // masked ch0 mismatching
        vq.push_back(mk(0, 1, 4'hE, 4'hF, 4'h1, 32'hFF, 2'd1, 16'd0, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        for (int k = 1; k <= 8; k++)
            vq.push_back(mk(0, 1, 4'hE, 4'hF, 4'h1, 32'hFF, 2'd1, 16'(3*k), 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        // disarm holds counters; IDLE cycle discards mismatches
        vq.push_back(mk(0, 0, 4'hF, 4'hF, 4'h0, 32'h0, 2'd0, 16'd24, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'hF, 32'hFF, 2'd1, 16'd24, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));
        // four errors in one cycle jump past threshold; MSB-only difference
        vq.push_back(mk(0, 1, 4'hF, 4'hF, 4'hF, 32'h8000_0000, 2'd2, 16'd28, 16'd4, e_d, 1, 2'd0, 32'h55, 32'h8000_0055));
        vq.push_back(mk(1, 0, 4'h0, 4'h0, 4'h0, 32'h0, 2'd0, 16'd0, 16'd0, 64'd0, 0, 2'd0, 32'h0, 32'h0));

        // reset, then 5 idle cycles
        rst_n = 1'b0;
        drive(0, 0, 4'h0, 4'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) cyc();
        chk("rst state",   64'(a_st),   64'd0);
        chk("rst cmp",     64'(a_cmp),  64'd0);
        chk("rst tot",     64'(a_tot),  64'd0);
        chk("rst err",     a_err,       64'd0);
        chk("rst fvld",    64'(a_fvld), 64'd0);
        chk("rst fch",     64'(a_fch),  64'd0);
        chk("rst fexp",    64'(a_fexp), 64'd0);
        chk("rst fact",    64'(a_fact), 64'd0);
        chk("rst finish",  64'(a_fin),  64'd0);

        foreach (vq[i]) begin
            drive(vq[i].clr, vq[i].en, vq[i].mask, vq[i].vld, vq[i].mis, vq[i].xr);
            cyc();
            chk($sformatf("v%0d state", i),  64'(a_st),   64'(vq[i].e_st));
            chk($sformatf("v%0d cmp", i),    64'(a_cmp),  64'(vq[i].e_cmp));
            chk($sformatf("v%0d tot", i),    64'(a_tot),  64'(vq[i].e_tot));
            chk($sformatf("v%0d err", i),    a_err,       vq[i].e_err);
            chk($sformatf("v%0d fvld", i),   64'(a_fvld), 64'(vq[i].e_fvld));
            chk($sformatf("v%0d fch", i),    64'(a_fch),  64'(vq[i].e_fch));
            chk($sformatf("v%0d fexp", i),   64'(a_fexp), 64'(vq[i].e_fexp));
            chk($sformatf("v%0d fact", i),   64'(a_fact), 64'(vq[i].e_fact));
            chk($sformatf("v%0d finish", i), 64'(a_fin),  64'(vq[i].e_st == 2'd2));
        end

        // saturation: ch2 mismatching for 20 cycles on 4-bit counters
        drive(1, 0, 4'h0, 4'h0, 4'h0, 32'h0);
        cyc();
        drive(0, 1, 4'hF, 4'hF, 4'h0, 32'h0);
        cyc();
        for (int k = 1; k <= 20; k++) begin
            drive(0, 1, 4'hF, 4'b0100, 4'b0100, 32'hFF);
            cyc();
            w = (k > 15) ? 16'd15 : 16'(k);
            chk($sformatf("sat%0d err2", k),  64'(s_err[11:8]), 64'(w));
            chk($sformatf("sat%0d tot", k),   64'(s_tot),       64'(w));
            chk($sformatf("sat%0d cmp", k),   64'(s_cmp),       64'(w));
            chk($sformatf("sat%0d state", k), 64'(s_st),        64'd1);
        end
        chk("sat err others", 64'({s_err[15:12], s_err[7:0]}), 64'd0);

        // multi-channel add into saturation; threshold on the unsaturated sum
        drive(1, 0, 4'h0, 4'h0, 4'h0, 32'h0);
        cyc();
        drive(0, 1, 4'hF, 4'hF, 4'h0, 32'h0);
        cyc();
        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 4'hF, 4'hF, 4'hF, 32'hFF);
            cyc();
            chk($sformatf("madd%0d s_tot", k),   64'(s_tot),      64'((4*k > 15) ? 15 : 4*k));
            chk($sformatf("madd%0d t_tot", k),   64'(t_tot),      64'd3);
            chk($sformatf("madd%0d t_err0", k),  64'(t_err[1:0]), 64'((k > 3) ? 3 : k));
            chk($sformatf("madd%0d t_state", k), 64'(t_st),       64'((k == 1) ? 1 : 2));
            chk($sformatf("madd%0d t_finish", k), 64'(t_fin),     64'(k >= 2));
        end

        // asynchronous reset mid-cycle, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst t_state",  64'(t_st),   64'd0);
        chk("arst t_finish", 64'(t_fin),  64'd0);
        chk("arst t_err",    64'(t_err),  64'd0);
        chk("arst s_tot",    64'(s_tot),  64'd0);
        chk("arst s_fvld",   64'(s_fvld), 64'd0);
        chk("arst s_fact",   64'(s_fact), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
